// File: rtl/window_3x3_l1_if.sv
// Pixel-stream and window bus for the 3x3 window builder.
// The master drives the pixel column (current row plus two row-delayed taps);
// the slave returns the assembled window and the frame status pulses.
interface window_3x3_l1_if #(
    parameter int DATA_W = 16
);
    logic                  in_valid;
    logic                  in_sof;
    logic [DATA_W-1:0]     pix_in;
    logic [DATA_W-1:0]     row1_in;
    logic [DATA_W-1:0]     row2_in;
    logic                  win_valid;
    logic [9*DATA_W-1:0]   win_out;
    logic                  frame_done;
    logic                  err;

    modport master (
        output in_valid, in_sof, pix_in, row1_in, row2_in,
        input  win_valid, win_out, frame_done, err
    );

    modport slave (
        input  in_valid, in_sof, pix_in, row1_in, row2_in,
        output win_valid, win_out, frame_done, err
    );
endinterface

// File: rtl/window_3x3_l1.sv
// 3x3 sliding-window builder. Takes one pixel column per cycle (row R, R-1,
// R-2 from upstream row delays), shifts it into a 3x3 register window and
// flags the cycles where the window lies fully inside the image.
// w[r][c] sits at bits DATA_W*(3r+c); r=0 oldest row, c=0 oldest column.
module window_3x3_l1 #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    window_3x3_l1_if.slave   bus
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] col;        // column of the next pixel expected
    logic [RW-1:0] row;        // row of the next pixel expected

    logic          restart;    // in_sof qualified by in_valid, any state
    logic          accept;     // this pixel belongs to a frame
    logic [CW-1:0] pos_c;
    logic [RW-1:0] pos_r;
    logic          at_win;
    logic          last;
    logic          abort;
    logic          sof_err;

    logic [2:0][DATA_W-1:0] col_in;   // index = window row
    logic [2:0][DATA_W-1:0] win [3];  // win[r][c]

    // Row 0 of the window is the oldest row (two rows back).
    assign col_in = {bus.pix_in, bus.row1_in, bus.row2_in};
    assign bus.win_out = {win[2], win[1], win[0]};

    // Position of the pixel on the bus this cycle and the events it triggers.
    // A qualified in_sof always makes the current pixel (0,0), even mid-frame.
    always_comb begin
        restart = bus.in_valid && bus.in_sof;
        accept  = bus.in_valid && (bus.in_sof || state == ACTIVE);
        pos_c   = restart ? '0 : col;
        pos_r   = restart ? '0 : row;
        at_win  = accept && (pos_r >= RW'(2)) && (pos_c >= CW'(2));
        last    = accept && (pos_r == RW'(IMG_H-1)) && (pos_c == CW'(IMG_W-1));
        abort   = (state == ACTIVE) && !bus.in_valid;
        sof_err = (state == ACTIVE) && restart && ((row != '0) || (col != '0));
    end

    // Frame FSM and raster counters; counters always point at the next pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else if (restart) begin
            state <= ACTIVE;
            col   <= CW'(1);
            row   <= '0;
        end else if (state == ACTIVE) begin
            if (!bus.in_valid || last) begin
                state <= IDLE;
                col   <= '0;
                row   <= '0;
            end else if (col == CW'(IMG_W-1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Status outputs, registered so they line up with the window they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.win_valid  <= at_win;
            bus.frame_done <= last;
            bus.err        <= abort || sof_err;
        end
    end

    // Window shift: every valid pixel moves each row left one column and loads
    // the new column on the right, regardless of frame state.
    for (genvar r = 0; r < 3; r++) begin : g_row
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                win[r] <= '0;
            else if (bus.in_valid)
                win[r] <= {col_in[r], win[r][2], win[r][1]};
        end
    end
endmodule

// File: tb/tb_window_3x3_l1.sv
// Directed bench for window_3x3_l1 on a 12x12 frame with pix = R*12+C and the
// row taps produced by a true delay line of the driven pixel stream.
module tb_window_3x3_l1;
    localparam int DW = 16;

    logic clk;
    logic rst_n;

    window_3x3_l1_if #(.DATA_W(DW)) bus ();

    window_3x3_l1 #(.DATA_W(DW), .IMG_W(12), .IMG_H(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Pixel history for the upstream row-delay model.
    logic [DW-1:0] hist [0:4095];
    int            n_hist = 0;

    // Per-scenario observations.
    int            nwin, nfd, nerr, bad, first_pos, fd_pos;
    logic [9*DW-1:0] first_w, last_w;

    task automatic clr();
        nwin = 0; nfd = 0; nerr = 0; bad = 0; first_pos = -1; fd_pos = -1;
        first_w = '0; last_w = '0;
    endtask

    // Drive one cycle and sample 1 time unit after the rising edge.
    task automatic drive(input bit v, input bit sof, input logic [DW-1:0] p);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.pix_in   = p;
        bus.row1_in  = (n_hist >= 12) ? hist[n_hist-12] : '0;
        bus.row2_in  = (n_hist >= 24) ? hist[n_hist-24] : '0;
        if (v) begin
            hist[n_hist] = p;
            n_hist++;
        end
        @(posedge clk);
        #1;
    endtask

    // Feed frame pixel (R,C); act says whether the block should treat it as
    // part of a running frame. Records windows and tallies unexpected output.
    task automatic feed(input int R, input int C, input bit sof, input bit act);
        logic [9*DW-1:0] expw;
        bit exp_v, exp_fd;
        drive(1'b1, sof, DW'(R*12 + C));
        exp_v  = act && R >= 2 && C >= 2;
        exp_fd = act && R == 11 && C == 11;
        expw   = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                expw[DW*(3*r+c) +: DW] = DW'((R-2+r)*12 + (C-2+c));
        if (bus.win_valid === 1'b1) begin
            if (nwin == 0) begin
                first_pos = R*12 + C;
                first_w   = bus.win_out;
            end
            nwin++;
            last_w = bus.win_out;
        end
        if (bus.win_valid !== exp_v) bad++;
        if (exp_v && bus.win_out !== expw) bad++;
        if (bus.frame_done === 1'b1) begin
            nfd++;
            fd_pos = R*12 + C;
        end
        if (bus.frame_done !== exp_fd) bad++;
        if (bus.err === 1'b1) nerr++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        bus.pix_in = '0; bus.row1_in = '0; bus.row2_in = '0;
        #3;
        n_assert++; if (bus.win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid got %b want 0", bus.win_valid); end
        n_assert++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        n_assert++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
        n_assert++; if (bus.win_out !== '0) begin n_fail++; $display("FAIL reset_win_out got %h want 0", bus.win_out); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_full_frame();
        clr();
        for (int i = 0; i < 144; i++) feed(i/12, i%12, i == 0, 1'b1);
        n_assert++; if (nwin !== 100) begin n_fail++; $display("FAIL full_win_count got %0d want 100", nwin); end
        n_assert++; if (first_pos !== 26) begin n_fail++; $display("FAIL full_first_pos got %0d want 26", first_pos); end
        n_assert++; if (first_w[0 +: DW] !== 16'd0) begin n_fail++; $display("FAIL full_first_w00 got %0d want 0", first_w[0 +: DW]); end
        n_assert++; if (first_w[DW*8 +: DW] !== 16'd26) begin n_fail++; $display("FAIL full_first_w22 got %0d want 26", first_w[DW*8 +: DW]); end
        n_assert++; if (nfd !== 1 || fd_pos !== 143) begin n_fail++; $display("FAIL full_frame_done got count %0d pos %0d want 1 at 143", nfd, fd_pos); end
        n_assert++; if (last_w[0 +: DW] !== 16'd117) begin n_fail++; $display("FAIL full_last_w00 got %0d want 117", last_w[0 +: DW]); end
        n_assert++; if (last_w[DW*8 +: DW] !== 16'd143) begin n_fail++; $display("FAIL full_last_w22 got %0d want 143", last_w[DW*8 +: DW]); end
        n_assert++; if (nerr !== 0 || bad !== 0) begin n_fail++; $display("FAIL full_clean got err %0d bad %0d want 0 0", nerr, bad); end
        // Frame is over: a valid pixel without in_sof must be ignored.
        drive(1'b1, 1'b0, 16'd999);
        n_assert++; if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL full_idle_after got v %b fd %b want 0 0", bus.win_valid, bus.frame_done); end
    endtask

    task automatic test_drop();
        clr();
        for (int i = 0; i < 50; i++) feed(i/12, i%12, i == 0, 1'b1);
        drive(1'b0, 1'b0, 16'd50);
        n_assert++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL drop_err_pulse got %b want 1", bus.err); end
        n_assert++; if (bus.win_valid !== 1'b0) begin n_fail++; $display("FAIL drop_win_valid got %b want 0", bus.win_valid); end
        for (int i = 51; i < 144; i++) feed(i/12, i%12, 1'b0, 1'b0);
        n_assert++; if (nwin !== 20) begin n_fail++; $display("FAIL drop_win_count got %0d want 20", nwin); end
        n_assert++; if (nfd !== 0 || nerr !== 0 || bad !== 0) begin n_fail++; $display("FAIL drop_after got fd %0d err %0d bad %0d want 0 0 0", nfd, nerr, bad); end
    endtask

    task automatic test_restart();
        clr();
        for (int i = 0; i < 30; i++) feed(i/12, i%12, i == 0, 1'b1);
        feed(0, 0, 1'b1, 1'b1);
        n_assert++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL restart_err got %b want 1", bus.err); end
        for (int i = 1; i < 144; i++) feed(i/12, i%12, 1'b0, 1'b1);
        n_assert++; if (nwin !== 104) begin n_fail++; $display("FAIL restart_win_count got %0d want 104", nwin); end
        n_assert++; if (nerr !== 1 || nfd !== 1 || fd_pos !== 143) begin n_fail++; $display("FAIL restart_status got err %0d fd %0d pos %0d want 1 1 143", nerr, nfd, fd_pos); end
        n_assert++; if (bad !== 0) begin n_fail++; $display("FAIL restart_windows got %0d bad want 0", bad); end
    endtask

    task automatic test_back_to_back();
        clr();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 144; i++) feed(i/12, i%12, i == 0, 1'b1);
        n_assert++; if (nwin !== 200) begin n_fail++; $display("FAIL b2b_win_count got %0d want 200", nwin); end
        n_assert++; if (nfd !== 2) begin n_fail++; $display("FAIL b2b_frame_done got %0d want 2", nfd); end
        n_assert++; if (nerr !== 0 || bad !== 0) begin n_fail++; $display("FAIL b2b_clean got err %0d bad %0d want 0 0", nerr, bad); end
    endtask

    task automatic test_reset_mid();
        clr();
        for (int i = 0; i < 40; i++) feed(i/12, i%12, i == 0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_assert++; if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got v %b fd %b err %b want 0 0 0", bus.win_valid, bus.frame_done, bus.err); end
        n_assert++; if (bus.win_out !== '0) begin n_fail++; $display("FAIL rstmid_win_out got %h want 0", bus.win_out); end
        for (int i = 40; i < 43; i++) drive(1'b1, 1'b0, DW'(i));
        n_assert++; if (bus.win_out !== '0 || bus.win_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold got v %b w %h want 0 0", bus.win_valid, bus.win_out); end
        rst_n = 1'b1;
        clr();
        for (int i = 43; i < 144; i++) feed(i/12, i%12, 1'b0, 1'b0);
        n_assert++; if (nwin !== 0 || nfd !== 0 || nerr !== 0 || bad !== 0) begin n_fail++; $display("FAIL rstmid_idle got win %0d fd %0d err %0d bad %0d want 0", nwin, nfd, nerr, bad); end
        for (int i = 0; i < 144; i++) feed(i/12, i%12, i == 0, 1'b1);
        n_assert++; if (nwin !== 100 || nfd !== 1 || bad !== 0) begin n_fail++; $display("FAIL rstmid_next_frame got win %0d fd %0d bad %0d want 100 1 0", nwin, nfd, bad); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_drop();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/window_3x3_l1.md
WINDOW_3X3_L1 -- requirements
Module: window_3x3_l1

Interface
REQ-001 Parameter DATA_W, default 16, pixel width in bits.
REQ-002 Parameter IMG_W, default 12, pixels per row; equals the delay depth of the upstream row-delay stages.
REQ-003 Parameter IMG_H, default 12, rows per frame; IMG_W and IMG_H SHALL each be >= 3.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  pixel on pix_in is valid this cycle; must stay high for the whole frame.
REQ-007 in_sof  input  1  start of frame; qualifies pixel (0,0); honoured only when in_valid=1.
REQ-008 pix_in  input  DATA_W  current pixel, row R.
REQ-009 row1_in  input  DATA_W  same column, row R-1 (pix_in delayed IMG_W cycles).
REQ-010 row2_in  input  DATA_W  same column, row R-2 (pix_in delayed 2*IMG_W cycles).
REQ-011 win_valid  output  1  win_out holds a complete in-image 3x3 window.
REQ-012 win_out  output  9*DATA_W  window; w[r][c] at bits DATA_W*(3r+c) +: DATA_W, r=0 oldest row, c=0 oldest column.
REQ-013 frame_done  output  1  one-cycle pulse on the last window of a frame.
REQ-014 err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-015 The block SHALL have states IDLE and ACTIVE.
REQ-016 IDLE -> ACTIVE when in_valid=1 and in_sof=1; that pixel is position (0,0).
REQ-017 In IDLE, pixels with in_sof=0 SHALL be ignored with no output activity.
REQ-018 In ACTIVE each in_valid=1 cycle SHALL advance col 0..IMG_W-1, wrapping to 0 and incrementing row 0..IMG_H-1.
REQ-019 Each in_valid=1 cycle (any state) SHALL shift the window left one column, loading column 2 with {row2_in, row1_in, pix_in} as rows 0,1,2.
REQ-020 win_valid SHALL be 1 exactly the cycle after accepting pixel (R,C) with R>=2 and C>=2, else 0.
REQ-021 When win_valid=1, w[r][c] SHALL equal pixel (R-2+r, C-2+c); w[2][2]=pixel (R,C).
REQ-022 Latency pix_in -> win_out SHALL be 1 clock; exactly (IMG_H-2)*(IMG_W-2) windows per frame.
REQ-023 frame_done SHALL assert with the win_valid for pixel (IMG_H-1, IMG_W-1); state returns to IDLE in that same transition.
REQ-024 in_valid=0 in ACTIVE SHALL abort: err pulses next cycle, state -> IDLE, no further win_valid for that frame.
REQ-025 in_sof=1 with in_valid=1 in ACTIVE at a position other than (0,0) SHALL pulse err and restart the frame with that pixel as (0,0).
REQ-026 in_sof on the cycle after frame_done SHALL start a new frame with no gap cycle.
REQ-027 win_out SHALL hold its last value while win_valid=0; consumers ignore it.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counters 0, win_valid=0, frame_done=0, err=0, win_out all zeros.
REQ-029 Reset mid-frame SHALL discard the frame; after release, only in_sof restarts operation.

Verification
REQ-030 12x12 frame, pix=R*12+C, row inputs modelled as true delays -> first win_valid the cycle after pixel 26 with w00=0, w22=26; 100 windows total.
REQ-031 Same frame -> frame_done and last win_valid coincide, w00=117, w22=143; state IDLE next cycle.
REQ-032 Drop in_valid at pixel 50 -> err one cycle, no further win_valid, frame_done never asserts.
REQ-033 Second in_sof at pixel 30 -> err pulse; pixel 30 becomes (0,0); 100 windows follow, then frame_done.
REQ-034 Two back-to-back frames, in_sof the cycle after frame_done -> 200 windows, two frame_done pulses, no err.
REQ-035 rst_n low at pixel 40, released 3 cycles later, in_valid held high with in_sof=0 -> all outputs 0, no win_valid until next in_sof.
